btn_led_ctrl: RTL and testbench

BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

---
 rtl/btn_led_ctrl.sv | 172 +++++++++++++++++
 tb/tb_btn_led_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: push-button front end for the LED blink stage.
//
// Synchronises the raw active-low button, debounces presses and releases,
// tells short presses from long ones, and drives the blink stage's LED
// enable level.
//
// Ports
//   clk            in   single clock for all logic
//   rst            in   asynchronous active-high reset
//   btn_n          in   raw push-button, active-low, asynchronous
//   led_ctrl       out  registered LED enable level
//   press_pulse    out  one-cycle strobe on an accepted press
//   long_pulse     out  one-cycle strobe when a press becomes a long press
//   release_pulse  out  one-cycle strobe on an accepted release
//
// State      | meaning
// IDLE       | button released and debounced
// DEB_PRESS  | button seen pressed, counting stable samples
// PRESSED    | press accepted, counting hold time towards a long press
// LONG       | long press detected, hold counter saturated
// DEB_REL    | button seen released, counting stable samples

module btn_led_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic led_ctrl,
    output logic press_pulse,
    output logic long_pulse,
    output logic release_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG,
        DEB_REL
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn;

    state_t          state_q, state_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            long_flag_q, long_flag_d;
    logic            led_q, led_d;
    logic            press_q, press_d;
    logic            long_q, long_d;
    logic            rel_q, rel_d;

    // Synchroniser resets to the released level so a reset never looks
    // like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign btn = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            led_q       <= 1'b0;
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            led_q       <= led_d;
            press_q     <= press_d;
            long_q      <= long_d;
            rel_q       <= rel_d;
        end
    end

    // Strobes are only raised on state-changing transitions, and exactly one
    // transition happens per cycle, so they can never overlap.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        led_d       = led_q;
        press_d     = 1'b0;
        long_d      = 1'b0;
        rel_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d     = LONG;
                    long_flag_d = 1'b1;
                    long_d      = 1'b1;
                    led_d       = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                // hold_cnt stays at its maximum here
                if (!btn) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = '0;
                end
            end
            DEB_REL: begin
                // hold_cnt is frozen so a release bounce does not lose hold time
                if (btn) begin
                    state_d = long_flag_q ? LONG : PRESSED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d     = IDLE;
                    rel_d       = 1'b1;
                    long_flag_d = 1'b0;
                    if (!long_flag_q) begin
                        led_d = ~led_q;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign led_ctrl      = led_q;
    assign press_pulse   = press_q;
    assign long_pulse    = long_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
module tb_btn_led_ctrl;

    logic clk;
    logic rst;
    logic btn_n;
    logic led_ctrl;
    logic press_pulse;
    logic long_pulse;
    logic release_pulse;

    int checks;
    int errors;

    // per-scenario trace; events recorded by the index of the edge after
    // which the output was seen high (edge 0 = first edge of the scenario)
    int   cyc_idx;
    int   press_cnt, long_cnt, rel_cnt, multi;
    int   press_at, long_at, rel_at;
    logic led_tr [0:63];

    btn_led_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .led_ctrl     (led_ctrl),
        .press_pulse  (press_pulse),
        .long_pulse   (long_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_stats();
        cyc_idx   = 0;
        press_cnt = 0;
        long_cnt  = 0;
        rel_cnt   = 0;
        multi     = 0;
        press_at  = -1;
        long_at   = -1;
        rel_at    = -1;
        for (int i = 0; i < 64; i++) led_tr[i] = 1'bx;
    endtask

    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            btn_n = b;
            @(posedge clk);
            #1;
            if (press_pulse === 1'b1) begin press_cnt++; press_at = cyc_idx; end
            if (long_pulse === 1'b1) begin long_cnt++; long_at = cyc_idx; end
            if (release_pulse === 1'b1) begin rel_cnt++; rel_at = cyc_idx; end
            if ((int'(press_pulse === 1'b1) + int'(long_pulse === 1'b1) +
                 int'(release_pulse === 1'b1)) > 1) multi++;
            if (cyc_idx < 64) led_tr[cyc_idx] = led_ctrl;
            cyc_idx++;
        end
    endtask

    task automatic idle_gap();
        drive(1'b1, 8);
        clear_stats();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        btn_n = 1'b0;
        #1;
        checks++;
        if ({led_ctrl, press_pulse, long_pulse, release_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000",
                     {led_ctrl, press_pulse, long_pulse, release_pulse});
        end
        clear_stats();
        drive(1'b0, 8);
        checks++;
        if (press_cnt + long_cnt + rel_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_strobe got %0d strobes exp 0", press_cnt + long_cnt + rel_cnt);
        end
        checks++;
        if (led_ctrl !== 1'b0) begin
            errors++;
            $display("FAIL reset_led got %b exp 0", led_ctrl);
        end
        btn_n = 1'b1;
        drive(1'b1, 4);
        rst = 1'b0;
        idle_gap();
    endtask

    task automatic test_short();
        drive(1'b0, 10);
        drive(1'b1, 10);
        checks++;
        if (press_cnt !== 1 || press_at !== 6) begin
            errors++;
            $display("FAIL short1_press got cnt %0d at %0d exp cnt 1 at 6", press_cnt, press_at);
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 16) begin
            errors++;
            $display("FAIL short1_release got cnt %0d at %0d exp cnt 1 at 16", rel_cnt, rel_at);
        end
        checks++;
        if (long_cnt !== 0 || multi !== 0) begin
            errors++;
            $display("FAIL short1_long_or_overlap got long %0d overlap %0d exp 0 0", long_cnt, multi);
        end
        checks++;
        if (led_tr[15] !== 1'b0 || led_tr[16] !== 1'b1) begin
            errors++;
            $display("FAIL short1_led_toggle got %b->%b exp 0->1", led_tr[15], led_tr[16]);
        end
        idle_gap();
        drive(1'b0, 10);
        drive(1'b1, 10);
        checks++;
        if (press_cnt !== 1 || press_at !== 6 || rel_cnt !== 1 || rel_at !== 16) begin
            errors++;
            $display("FAIL short2_strobes got press %0d@%0d rel %0d@%0d exp 1@6 1@16",
                     press_cnt, press_at, rel_cnt, rel_at);
        end
        checks++;
        if (led_ctrl !== 1'b0) begin
            errors++;
            $display("FAIL short2_led got %b exp 0", led_ctrl);
        end
        idle_gap();
    endtask

    task automatic test_bounce();
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 3);
        drive(1'b1, 10);
        checks++;
        if (press_cnt + long_cnt + rel_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_no_strobe got %0d strobes exp 0", press_cnt + long_cnt + rel_cnt);
        end
        checks++;
        if (led_ctrl !== 1'b0) begin
            errors++;
            $display("FAIL bounce_led got %b exp 0", led_ctrl);
        end
        idle_gap();
    endtask

    task automatic test_long();
        drive(1'b0, 10);
        drive(1'b1, 10);
        checks++;
        if (led_ctrl !== 1'b1) begin
            errors++;
            $display("FAIL long_setup_led got %b exp 1", led_ctrl);
        end
        idle_gap();
        drive(1'b0, 30);
        drive(1'b1, 12);
        checks++;
        if (press_cnt !== 1 || press_at !== 6) begin
            errors++;
            $display("FAIL long_press got cnt %0d at %0d exp cnt 1 at 6", press_cnt, press_at);
        end
        checks++;
        if (long_cnt !== 1 || long_at !== 22) begin
            errors++;
            $display("FAIL long_pulse got cnt %0d at %0d exp cnt 1 at 22", long_cnt, long_at);
        end
        checks++;
        if (led_tr[21] !== 1'b1 || led_tr[22] !== 1'b0) begin
            errors++;
            $display("FAIL long_led_clear got %b->%b exp 1->0", led_tr[21], led_tr[22]);
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 36) begin
            errors++;
            $display("FAIL long_release got cnt %0d at %0d exp cnt 1 at 36", rel_cnt, rel_at);
        end
        checks++;
        if (led_ctrl !== 1'b0 || multi !== 0) begin
            errors++;
            $display("FAIL long_led_after_release got led %b overlap %0d exp 0 0", led_ctrl, multi);
        end
        idle_gap();
    endtask

    task automatic test_release_bounce();
        drive(1'b0, 10);
        drive(1'b1, 2);
        drive(1'b0, 18);
        drive(1'b1, 12);
        checks++;
        if (press_cnt !== 1 || press_at !== 6) begin
            errors++;
            $display("FAIL relb_press got cnt %0d at %0d exp cnt 1 at 6", press_cnt, press_at);
        end
        checks++;
        if (long_cnt !== 1 || long_at !== 25) begin
            errors++;
            $display("FAIL relb_long got cnt %0d at %0d exp cnt 1 at 25", long_cnt, long_at);
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 36) begin
            errors++;
            $display("FAIL relb_release got cnt %0d at %0d exp cnt 1 at 36", rel_cnt, rel_at);
        end
        idle_gap();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 10);
        rst = 1'b1;
        drive(1'b0, 1);
        rst = 1'b0;
        drive(1'b0, 29);
        drive(1'b1, 12);
        checks++;
        if (press_cnt !== 2 || press_at !== 17) begin
            errors++;
            $display("FAIL rstmid_repress got cnt %0d last at %0d exp cnt 2 last at 17",
                     press_cnt, press_at);
        end
        checks++;
        if (long_cnt !== 1 || long_at !== 33) begin
            errors++;
            $display("FAIL rstmid_long got cnt %0d at %0d exp cnt 1 at 33 (none at 22)",
                     long_cnt, long_at);
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 46 || led_ctrl !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release got cnt %0d at %0d led %b exp 1 at 46 led 0",
                     rel_cnt, rel_at, led_ctrl);
        end
        idle_gap();
    endtask

    task automatic test_reset_async();
        drive(1'b0, 10);
        drive(1'b1, 10);
        clear_stats();
        drive(1'b0, 7);
        checks++;
        if (press_pulse !== 1'b1 || led_ctrl !== 1'b1) begin
            errors++;
            $display("FAIL async_setup got press %b led %b exp 1 1", press_pulse, led_ctrl);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({led_ctrl, press_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL async_clear got led,press %b exp 00", {led_ctrl, press_pulse});
        end
        clear_stats();
        drive(1'b0, 5);
        drive(1'b1, 3);
        rst = 1'b0;
        drive(1'b1, 10);
        checks++;
        if (press_cnt + long_cnt + rel_cnt !== 0 || led_ctrl !== 1'b0) begin
            errors++;
            $display("FAIL async_quiet got %0d strobes led %b exp 0 0",
                     press_cnt + long_cnt + rel_cnt, led_ctrl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn_n  = 1'b1;
        clear_stats();
        test_reset();
        test_short();
        test_bounce();
        test_long();
        test_release_bounce();
        test_reset_mid();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
